mont_const_gen: RTL
===================

Name: mont_const_gen

Overview:
Parametrised successor to the fixed 1024-bit Montgomery constant unit. For an odd modulus M it computes R_r = 2^WIDTH mod M and R_t = 2^(2*WIDTH) mod M (the R and R^2 constants), using iterative modular doubling with BITS_PER_CYCLE doublings per clock. There is no wide multiplier. It sits ahead of the Montgomery multiplier in the RSA decrypt datapath and runs once per key load.

Parameters:
WIDTH, 1024, modulus and result width in bits; must be >= 4.
BITS_PER_CYCLE, 1, modular doublings per clock; must be 1, 2 or 4 and must divide WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
M  input  WIDTH  modulus; captured on the accepted start edge and ignored afterwards
R_r  output  WIDTH  2^WIDTH mod M; registered
R_t  output  WIDTH  2^(2*WIDTH) mod M; registered
busy  output  1  high while a computation is in progress
done  output  1  single-cycle completion pulse
err  output  1  high with done when M was rejected; holds until the next accepted start

Behaviour:
- Reset values: R_r=0, R_t=0, busy=0, done=0, err=0, state=IDLE. Reset applies on any clk edge with rst=1 and overrides everything, including mid-computation. The partial result is discarded and no done pulse is issued.
- States: IDLE, CALC_R, CALC_T. Internal accumulator a is WIDTH+1 bits; step counter cnt counts WIDTH/BITS_PER_CYCLE steps.
- IDLE:
  - On an edge with start=1: latch M into m_reg, clear err.
  - If M is even or M < 3: stay IDLE, set R_r=0, R_t=0, err=1, done=1 on the next cycle. Latency 1.
  - Otherwise: a=1, cnt=WIDTH/BITS_PER_CYCLE, busy=1, go to CALC_R.
- Doubling step, applied BITS_PER_CYCLE times combinationally per clock: a = 2a; if a >= m_reg then a = a - m_reg. Since a < m_reg is invariant, one conditional subtract suffices. Compare and subtract are WIDTH+1 bits wide.
- CALC_R: perform one step group per clock and decrement cnt. On the edge where cnt reaches 0: store a into internal r_hold, reload cnt=WIDTH/BITS_PER_CYCLE, go to CALC_T. Continue from the same a; do not reset it.
- CALC_T: same stepping. On the edge where cnt reaches 0, all in that same edge:
  - R_r <= r_hold and R_t <= a[WIDTH-1:0];
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high exactly 2*WIDTH/BITS_PER_CYCLE cycles after the accepted start edge. busy is high for those cycles, excluding the done cycle.
- done is high for exactly one cycle. R_r, R_t and err hold their values until the next accepted start (err) or the next completion (R_r, R_t).
- R_r and R_t never show partial results. The previous pair stays visible throughout a new computation.
- start while busy=1 is ignored. M changes while busy have no effect.
- start high in the done cycle is accepted, since the state is IDLE. A new computation begins back-to-back. done drops in the following cycle unless that start is a rejected M.
- Holding start high continuously re-triggers the computation on every return to IDLE.

Test Plan:
- WIDTH=8, BITS_PER_CYCLE=1, M=13, start for 1 cycle -> done 16 cycles later; R_r=9, R_t=3, err=0; busy high for 16 cycles.
- WIDTH=8, BITS_PER_CYCLE=4: M=129 -> done after 4 cycles, R_r=127, R_t=4. Then M=255 back-to-back with start in the done cycle -> R_r=1, R_t=1; the 127/4 pair stays visible until the second done.
- WIDTH=8: M=12, then M=1, then M=0 -> each gives a done pulse 1 cycle after start with err=1 and R_r=R_t=0. The next valid M=13 clears err at its start edge.
- WIDTH=16, BITS_PER_CYCLE=2, M=0xFFF1 -> done 16 cycles after start, R_r=15, R_t=225. Toggle M and pulse start mid-run -> no effect on the result or latency.
- Assert rst for 1 cycle at cycle 5 of a WIDTH=8 M=13 run -> all outputs 0 on the next cycle, no done pulse. A later start gives a full 16-cycle run with the correct result.
- WIDTH=1024, BITS_PER_CYCLE=1, M = a random odd 1024-bit value with the top bit set -> R_r and R_t match a big-integer reference model; done 2048 cycles after start.

Source files
------------

// File: rtl/mont_const_gen.sv
// -----------------------------------------------------------------------------
// mont_const_gen
//
// Purpose:
//   Computes the Montgomery constants for an odd modulus M:
//     R_r = 2^WIDTH     mod M
//     R_t = 2^(2*WIDTH) mod M
//   It uses iterative modular doubling, so no wide multiplier is needed.
//   The accumulator starts at 1 and is doubled modulo M.
//   After WIDTH doublings it holds R_r.
//   After WIDTH more doublings, continuing from the same value, it holds R_t.
//   BITS_PER_CYCLE doublings are chained combinationally in each clock.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   M      in   modulus, captured on the accepted start edge
//   R_r    out  2^WIDTH mod M (registered, updated only on completion)
//   R_t    out  2^(2*WIDTH) mod M (registered, updated only on completion)
//   busy   out  high while a computation is in progress
//   done   out  single-cycle completion pulse
//   err    out  set with done when M is even or below 3;
//               stays set until the next accepted start
// -----------------------------------------------------------------------------
module mont_const_gen #(
  parameter int WIDTH          = 1024,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] R_r,
  output logic [WIDTH-1:0] R_t,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] STEPS_C = CW'(STEPS);

  typedef enum logic [1:0] {IDLE, CALC_R, CALC_T} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   a_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_hold_q;
  logic [WIDTH-1:0] r_r_q;
  logic [WIDTH-1:0] r_t_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH:0]   m_ext;
  logic             m_bad;
  logic             cnt_last;

  assign m_ext    = {1'b0, m_q};
  // Even moduli, and moduli below 3 (0 and 1), have no usable Montgomery form.
  assign m_bad    = (~M[0]) || (M < WIDTH'(3));
  assign cnt_last = (cnt_q == CW'(1));

  // Chain of modular doublings.
  // Because a < m holds on entry to every stage, 2a < 2m.
  // A single conditional subtract therefore restores a < m.
  // 2a < 2^(WIDTH+1), so the WIDTH+1 bit shift never loses a set bit.
  logic [WIDTH:0] a_chain [BITS_PER_CYCLE+1];

  assign a_chain[0] = a_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [WIDTH:0] dbl;
    assign dbl            = a_chain[gi] << 1;
    assign a_chain[gi+1]  = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
  end

  assign a_d = a_chain[BITS_PER_CYCLE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      m_q      <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      r_hold_q <= '0;
      r_r_q    <= '0;
      r_t_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q   <= M;
            err_q <= 1'b0;
            if (m_bad) begin
              r_r_q  <= '0;
              r_t_q  <= '0;
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              a_q     <= {{WIDTH{1'b0}}, 1'b1};
              cnt_q   <= STEPS_C;
              busy_q  <= 1'b1;
              state_q <= CALC_R;
            end
          end
        end

        CALC_R: begin
          a_q <= a_d;
          if (cnt_last) begin
            // a_d now equals 2^WIDTH mod M.
            // Keep it hidden until the whole pair is ready.
            // Then carry on doubling from the same value.
            r_hold_q <= a_d[WIDTH-1:0];
            cnt_q    <= STEPS_C;
            state_q  <= CALC_T;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        CALC_T: begin
          a_q <= a_d;
          if (cnt_last) begin
            r_r_q   <= r_hold_q;
            r_t_q   <= a_d[WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign R_r  = r_r_q;
  assign R_t  = r_t_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
